// File: rtl/dm_copy_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_copy_engine_if
// Description : Data-memory port bundle shared by the copy engine (master)
//               and the memory-side mux / memory model (slave).
//               rd_dm_en   - read enable           (master -> slave)
//               wr_dm_en   - write enable          (master -> slave)
//               dm_addr    - word address          (master -> slave)
//               wr_dm_data - write data            (master -> slave)
//               rd_dm_data - read data             (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_copy_engine_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              rd_dm_en;
    logic              wr_dm_en;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] wr_dm_data;
    logic [DATA_W-1:0] rd_dm_data;

    modport master (
        output rd_dm_en,
        output wr_dm_en,
        output dm_addr,
        output wr_dm_data,
        input  rd_dm_data
    );

    modport slave (
        input  rd_dm_en,
        input  wr_dm_en,
        input  dm_addr,
        input  wr_dm_data,
        output rd_dm_data
    );
endinterface
`default_nettype wire

// File: rtl/dm_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : dm_copy_engine
// Description : Copies a block of len words from src_addr to dst_addr inside
//               the 64-word data memory, one word at a time (read, wait
//               RD_LAT cycles, write), accumulating a 16-bit checksum.
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - one-cycle request, sampled in IDLE only
//   src_addr   - first source word address (sampled with start)
//   dst_addr   - first destination word address (sampled with start)
//   len        - word count 0..64 (sampled with start)
//   busy       - engine owns the memory port
//   done       - one-cycle completion pulse
//   checksum   - sum of copied words mod 2^DATA_W
//   mem        - data-memory port (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module dm_copy_engine #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    dm_copy_engine_if.master  mem
);

    // Wait-counter value of the final WT cycle (RD_LAT is 1..3).
    localparam logic [1:0]      c_WT_LAST = 2'(RD_LAT - 1);
    localparam logic [ADDR_W:0] c_IDX_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WT   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // Word index never exceeds 63 while addressing, so the low bits suffice
    // and the additions wrap modulo the memory size naturally.
    assign idx_inc = idx_q + c_IDX_ONE;
    assign rd_addr = src_q + idx_q[ADDR_W-1:0];
    assign wr_addr = dst_q + idx_q[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            data_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        csum_d  = csum_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Any accepted start restarts the checksum, even an
                    // empty copy, so len=0 reports a checksum of zero.
                    csum_d = '0;
                    idx_d  = '0;
                    if (len != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = len;
                        state_d = S_RD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RD: begin
                wcnt_d  = '0;
                state_d = S_WT;
            end
            S_WT: begin
                if (wcnt_q == c_WT_LAST) begin
                    data_d  = mem.rd_dm_data;
                    csum_d  = csum_q + mem.rd_dm_data;
                    state_d = S_WR;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_WR: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? S_FIN : S_RD;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; nothing passes from inputs.
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_FIN);
        checksum       = csum_q;
        mem.rd_dm_en   = (state_q == S_RD);
        mem.wr_dm_en   = (state_q == S_WR);
        mem.dm_addr    = '0;
        mem.wr_dm_data = '0;
        if (state_q == S_RD) begin
            mem.dm_addr = rd_addr;
        end else if (state_q == S_WR) begin
            mem.dm_addr    = wr_addr;
            mem.wr_dm_data = data_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_copy_engine
// Description : Self-checking bench for dm_copy_engine. Two instances are
//               built (RD_LAT=1 and RD_LAT=3), each with its own memory
//               model. Expected memory images, checksums and bus traces are
//               derived from a word-by-word block-copy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_copy_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  start_v = '0;
    logic [5:0]  src_v [2];
    logic [5:0]  dst_v [2];
    logic [6:0]  len_v [2];
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [15:0] cks_v [2];

    logic [1:0]  rd_v;
    logic [1:0]  wr_v;
    logic [5:0]  addr_v  [2];
    logic [15:0] wdata_v [2];

    dm_copy_engine_if #(.ADDR_W(6), .DATA_W(16)) bus_a ();
    dm_copy_engine_if #(.ADDR_W(6), .DATA_W(16)) bus_b ();

    dm_copy_engine #(.ADDR_W(6), .DATA_W(16), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .src_addr(src_v[0]), .dst_addr(dst_v[0]), .len(len_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .checksum(cks_v[0]),
        .mem(bus_a)
    );

    dm_copy_engine #(.ADDR_W(6), .DATA_W(16), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .src_addr(src_v[1]), .dst_addr(dst_v[1]), .len(len_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .checksum(cks_v[1]),
        .mem(bus_b)
    );

    assign rd_v[0]    = bus_a.rd_dm_en;
    assign wr_v[0]    = bus_a.wr_dm_en;
    assign addr_v[0]  = bus_a.dm_addr;
    assign wdata_v[0] = bus_a.wr_dm_data;
    assign rd_v[1]    = bus_b.rd_dm_en;
    assign wr_v[1]    = bus_b.wr_dm_en;
    assign addr_v[1]  = bus_b.dm_addr;
    assign wdata_v[1] = bus_b.wr_dm_data;

    // ---------------- memory models ----------------
    logic [15:0] mem_a [64];
    logic [15:0] mem_b [64];
    logic [15:0] pipe_a [3];
    logic [15:0] pipe_b [3];
    logic        pre_en   = 1'b0;
    logic        pre_sel  = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en && !pre_sel)   mem_a[pre_addr] <= pre_data;
        else if (bus_a.wr_dm_en)  mem_a[bus_a.dm_addr] <= bus_a.wr_dm_data;
        pipe_a[0] <= bus_a.rd_dm_en ? mem_a[bus_a.dm_addr] : 16'($urandom);
        pipe_a[1] <= pipe_a[0];
        pipe_a[2] <= pipe_a[1];
    end

    always @(posedge clk) begin
        if (pre_en && pre_sel)    mem_b[pre_addr] <= pre_data;
        else if (bus_b.wr_dm_en)  mem_b[bus_b.dm_addr] <= bus_b.wr_dm_data;
        pipe_b[0] <= bus_b.rd_dm_en ? mem_b[bus_b.dm_addr] : 16'($urandom);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    assign bus_a.rd_dm_data = pipe_a[0];
    assign bus_b.rd_dm_data = pipe_b[2];

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] ref_mem [2][64];

    function automatic logic [15:0] mem_rd(input int s, input int a);
        return (s == 0) ? mem_a[a] : mem_b[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int s, input int a, input logic [15:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_sel  = (s != 0);
        pre_addr = 6'(a);
        pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
        ref_mem[s][a] = d;
    endtask

    task automatic mem_compare(input int s, input string tag);
        int mism = 0;
        for (int a = 0; a < 64; a++)
            if (mem_rd(s, a) !== ref_mem[s][a]) mism++;
        check(tag, 32'(mism), 32'd0);
    endtask

    // Runs one copy on instance s and checks timing, bus trace, checksum and
    // the resulting memory image against the block-copy model.
    task automatic run_copy(input int s, input int sa, input int da, input int ln,
                            input bit extra, output logic [15:0] sum_out);
        int          lat, per, done_n, rd_n, wr_n, err, done_at, done_cnt;
        int          exp_rd [$];
        int          exp_wr [$];
        logic [15:0] exp_wd [$];
        logic [15:0] exp_sum;
        logic [15:0] w;

        lat    = (s == 0) ? 1 : 3;
        per    = 2 + lat;
        done_n = ln * per + 1;

        exp_sum = '0;
        for (int k = 0; k < ln; k++) begin
            w = ref_mem[s][(sa + k) % 64];
            ref_mem[s][(da + k) % 64] = w;
            exp_sum = exp_sum + w;
            exp_rd.push_back((sa + k) % 64);
            exp_wr.push_back((da + k) % 64);
            exp_wd.push_back(w);
        end
        sum_out = exp_sum;

        @(negedge clk);
        start_v[s] = 1'b1;
        src_v[s]   = 6'(sa);
        dst_v[s]   = 6'(da);
        len_v[s]   = 7'(ln);
        @(posedge clk);

        rd_n = 0; wr_n = 0; err = 0; done_at = 0; done_cnt = 0;
        for (int n = 1; n <= done_n + 3; n++) begin
            @(negedge clk);
            if (n == 1) start_v[s] = 1'b0;
            if (extra && n == 2 && done_n > 3) begin
                start_v[s] = 1'b1;
                src_v[s]   = 6'd0;
                dst_v[s]   = 6'd0;
                len_v[s]   = 7'd5;
            end
            if (n == 3) start_v[s] = 1'b0;
            if (n == 1) check("busy_rise", 32'(busy_v[s]), 32'd1);

            if (rd_v[s] && wr_v[s]) err++;
            if (rd_v[s]) begin
                if (rd_n >= ln) err++;
                else if (int'(addr_v[s]) != exp_rd[rd_n] || n != 1 + rd_n * per) err++;
                rd_n++;
            end
            if (wr_v[s]) begin
                if (wr_n >= ln) err++;
                else if (int'(addr_v[s]) != exp_wr[wr_n] || wdata_v[s] !== exp_wd[wr_n] ||
                         n != per + wr_n * per) err++;
                wr_n++;
            end
            if (!rd_v[s] && !wr_v[s] && (addr_v[s] != 6'd0 || wdata_v[s] != 16'd0)) err++;
            if (busy_v[s] != (n <= done_n)) err++;
            if (done_v[s]) begin
                if (done_at == 0) done_at = n;
                done_cnt++;
            end
        end

        check("done_cycle", 32'(done_at), 32'(done_n));
        check("done_width", 32'(done_cnt), 32'd1);
        check("rd_count",   32'(rd_n), 32'(ln));
        check("wr_count",   32'(wr_n), 32'(ln));
        check("bus_trace",  32'(err), 32'd0);
        check("checksum",   32'(cks_v[s]), 32'(exp_sum));
        mem_compare(s, "mem_image");
    endtask

    initial begin
        logic [15:0] sum;
        logic [15:0] m41;
        int          wrn, dn;
        bit          hit;

        for (int s = 0; s < 2; s++) begin
            src_v[s] = '0; dst_v[s] = '0; len_v[s] = '0;
        end

        // Reset state, sampled off-edge while rst is high.
        #23;
        for (int s = 0; s < 2; s++) begin
            check("reset_ctrl", {26'd0, busy_v[s], done_v[s], rd_v[s], wr_v[s], addr_v[s]}, 32'd0);
            check("reset_data", {wdata_v[s], cks_v[s]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 64; a++)
                preload(s, a, 16'($urandom));

        // Basic copy, RD_LAT=1.
        preload(0, 5, 16'd1000); preload(0, 6, 16'd2000);
        preload(0, 7, 16'd3000); preload(0, 8, 16'd4000);
        run_copy(0, 5, 20, 4, 1'b0, sum);
        check("basic_sum", 32'(cks_v[0]), 32'h2710);

        // Wrap-around source.
        preload(0, 62, 16'd1); preload(0, 63, 16'd2);
        preload(0, 0, 16'd3);  preload(0, 1, 16'd4);
        run_copy(0, 62, 30, 4, 1'b0, sum);
        check("wrap_sum", 32'(cks_v[0]), 32'd10);

        // Empty copy.
        run_copy(0, 9, 9, 0, 1'b0, sum);
        check("len0_sum", 32'(cks_v[0]), 32'd0);

        // Forward-overlapping copy with an ignored start mid-copy.
        preload(0, 5, 16'd1000); preload(0, 6, 16'd2000); preload(0, 7, 16'd3000);
        run_copy(0, 5, 6, 3, 1'b1, sum);
        check("overlap_m8", 32'(mem_rd(0, 8)), 32'd1000);
        check("overlap_sum", 32'(cks_v[0]), 32'd3000);

        // Reset during the second write of a 4-word copy.
        preload(0, 10, 16'h1111); preload(0, 11, 16'h2222);
        preload(0, 12, 16'h3333); preload(0, 13, 16'h4444);
        preload(0, 40, 16'hA0A0); preload(0, 41, 16'hA1A1);
        preload(0, 42, 16'hA2A2); preload(0, 43, 16'hA3A3);
        @(negedge clk);
        start_v[0] = 1'b1; src_v[0] = 6'd10; dst_v[0] = 6'd40; len_v[0] = 7'd4;
        @(posedge clk);
        wrn = 0; dn = 0; hit = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) start_v[0] = 1'b0;
            if (wr_v[0]) wrn++;
            if (done_v[0]) dn++;
            if (wrn == 2) begin
                #2 rst = 1'b1;
                #1;
                check("rst_mid_ctrl", {26'd0, busy_v[0], done_v[0], rd_v[0], wr_v[0], addr_v[0]}, 32'd0);
                check("rst_mid_data", {wdata_v[0], cks_v[0]}, 32'd0);
                hit = 1'b1;
                break;
            end
        end
        check("rst_reached", 32'(hit), 32'd1);
        check("rst_no_done", 32'(dn), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m41 = mem_rd(0, 41);
        check("rst_word0", 32'(mem_rd(0, 40)), 32'h1111);
        check("rst_word1", 32'((m41 == 16'hA1A1) || (m41 == 16'h2222)), 32'd1);
        ref_mem[0][40] = 16'h1111;
        ref_mem[0][41] = m41;
        mem_compare(0, "rst_mem_image");
        run_copy(0, 10, 50, 4, 1'b0, sum);

        // Basic copy on the RD_LAT=3 build.
        preload(1, 5, 16'd1000); preload(1, 6, 16'd2000);
        preload(1, 7, 16'd3000); preload(1, 8, 16'd4000);
        run_copy(1, 5, 20, 4, 1'b0, sum);
        check("lat3_sum", 32'(cks_v[1]), 32'h2710);

        // Randomized copies on both builds.
        for (int r = 0; r < 10; r++) begin
            run_copy(r % 2, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), sum);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
